// File: rtl/bsg_vanilla_pkg.sv
// Shared definitions for the vanilla core's remote-load scoreboards.
// Holds the register-file geometry and the scoreboard sizing defaults. It also
// defines the valid+id port bundle that the core uses for the score, clear,
// src and dst interfaces.
package bsg_vanilla_pkg;

  localparam int RV32_reg_els_gp        = 32;
  localparam int RV32_reg_addr_width_gp = 5;

  localparam int vanilla_sb_cnt_width_gp = 2;
  localparam int vanilla_sb_num_clear_gp = 2;

  typedef struct packed {
    logic                              v;
    logic [RV32_reg_addr_width_gp-1:0] id;
  } sb_port_s;

endpackage

// File: rtl/vanilla_sb_entry.sv
// One scoreboard counter: the number of outstanding remote loads to a single
// register.
//   clk_i, reset_i : clock, async active-high reset
//   inc_i          : a load to this register is scored this cycle
//   dec_i          : number of responses retiring this register this cycle
//   cnt_o          : registered count
//   cnt_n_o        : count that will be loaded at the next edge
//   nonzero_o      : registered count != 0
module vanilla_sb_entry
  import bsg_vanilla_pkg::*;
#(
  parameter int cnt_width_p = vanilla_sb_cnt_width_gp,
  parameter int dec_width_p = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   inc_i,
  input  logic [dec_width_p-1:0] dec_i,
  output logic [cnt_width_p-1:0] cnt_o,
  output logic [cnt_width_p-1:0] cnt_n_o,
  output logic                   nonzero_o
);

  localparam int sum_width_lp = ((cnt_width_p > dec_width_p) ? cnt_width_p : dec_width_p) + 1;
  localparam logic [cnt_width_p-1:0] max_lp = '1;

  logic [cnt_width_p-1:0]  cnt_r;
  logic                    inc_ok;
  logic [sum_width_lp-1:0] sum, dec_ext;

  // A score against a saturated counter is dropped so the count holds at max.
  // More clears than outstanding loads clamp the count at zero.
  always_comb begin
    inc_ok  = inc_i & (cnt_r != max_lp);
    sum     = sum_width_lp'(cnt_r) + sum_width_lp'(inc_ok);
    dec_ext = sum_width_lp'(dec_i);
    cnt_n_o = (dec_ext > sum) ? '0 : cnt_width_p'(sum - dec_ext);
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) cnt_r <= '0;
    else         cnt_r <= cnt_n_o;

  assign cnt_o     = cnt_r;
  assign nonzero_o = (cnt_r != '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(inc_i && (cnt_r == max_lp)));
      assert (dec_ext <= sum);
    end
  end
`endif

endmodule

// File: rtl/vanilla_remote_load_scoreboard.sv
// Scoreboard of outstanding remote loads, one up/down counter per register.
// Several loads in flight to the same rd are legal.
//   clk_i, reset_i  : clock, async active-high reset
//   score_v_i/id_i  : issue of a remote load to a register
//   score_ready_o   : the addressed counter is not saturated
//   clear_v_i/id_i  : num_clear_p load-response ports (flattened ids)
//   src_v_i/id_i    : source operands of the ID-stage instruction
//   dst_v_i/id_i    : destination of the ID-stage instruction
//   dep_o           : RAW/WAW hazard after applying this cycle's clears
//   pending_o       : per-register counter != 0 (registered)
//   total_pending_o : sum of all counters (registered)
//   empty_o         : total_pending_o == 0 (registered)
module vanilla_remote_load_scoreboard
  import bsg_vanilla_pkg::*;
#(
  parameter  int els_p       = RV32_reg_els_gp,
  parameter  int cnt_width_p = vanilla_sb_cnt_width_gp,
  parameter  int num_src_p   = 3,
  parameter  int num_clear_p = vanilla_sb_num_clear_gp,
  parameter  int zero_reg_p  = 1,
  localparam int id_width_lp    = $clog2(els_p),
  localparam int total_width_lp = $clog2(els_p*(2**cnt_width_p-1)+1)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               score_v_i,
  input  logic [id_width_lp-1:0]             score_id_i,
  output logic                               score_ready_o,
  input  logic [num_clear_p-1:0]             clear_v_i,
  input  logic [num_clear_p*id_width_lp-1:0] clear_id_i,
  input  logic [num_src_p-1:0]               src_v_i,
  input  logic [num_src_p*id_width_lp-1:0]   src_id_i,
  input  logic                               dst_v_i,
  input  logic [id_width_lp-1:0]             dst_id_i,
  output logic                               dep_o,
  output logic [els_p-1:0]                   pending_o,
  output logic [total_width_lp-1:0]          total_pending_o,
  output logic                               empty_o
);

  localparam int dec_width_lp = $clog2(num_clear_p+1);
  localparam logic [cnt_width_p-1:0] max_lp = '1;

  logic [els_p-1:0]                  inc;
  logic [els_p-1:0][dec_width_lp-1:0] dec;
  logic [els_p-1:0][cnt_width_p-1:0]  cnt, cnt_n;
  logic [els_p-1:0]                  eff_nz;
  logic [total_width_lp-1:0]         total_n, total_r;
  logic                              empty_r;
  logic                              zero_hit;

  // Decode the score port and count the clears landing on each register;
  // duplicate ids on different ports add up.
  always_comb begin
    for (int i = 0; i < els_p; i++) begin
      inc[i] = score_v_i & (score_id_i == id_width_lp'(i));
      dec[i] = '0;
      for (int p = 0; p < num_clear_p; p++)
        if (clear_v_i[p] && (clear_id_i[p*id_width_lp +: id_width_lp] == id_width_lp'(i)))
          dec[i] = dec[i] + dec_width_lp'(1);
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : g_el
    if ((zero_reg_p != 0) && (i == 0)) begin : g_zero
      // Register 0 is hardwired: never scored, never pending.
      logic zero_unused;
      assign zero_unused  = inc[i];
      assign cnt[i]       = '0;
      assign cnt_n[i]     = '0;
      assign pending_o[i] = 1'b0;
    end else begin : g_cnt
      vanilla_sb_entry #(
        .cnt_width_p (cnt_width_p),
        .dec_width_p (dec_width_lp)
      ) entry (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .inc_i     (inc[i]),
        .dec_i     (dec[i]),
        .cnt_o     (cnt[i]),
        .cnt_n_o   (cnt_n[i]),
        .nonzero_o (pending_o[i])
      );
    end
  end

  // Clear bypass for hazard detection: a response arriving this cycle already
  // releases its register, but a load scored this cycle is not yet visible.
  always_comb begin
    for (int i = 0; i < els_p; i++)
      eff_nz[i] = (cnt_width_p+1)'(cnt[i]) > (cnt_width_p+1)'(dec[i]);
  end

  always_comb begin
    dep_o = dst_v_i & eff_nz[dst_id_i];
    for (int s = 0; s < num_src_p; s++)
      if (src_v_i[s] && eff_nz[src_id_i[s*id_width_lp +: id_width_lp]])
        dep_o = 1'b1;
  end

  // No clear-to-ready bypass: readiness looks only at registered state.
  assign zero_hit      = (zero_reg_p != 0) && (score_id_i == '0);
  assign score_ready_o = zero_hit | (cnt[score_id_i] != max_lp);

  // The running total is rebuilt from the next-state counters. It therefore
  // tracks exactly what the entries accept. Dropped scores, clamped clears
  // and reg-0 traffic never make it drift from the sum of the counters.
  always_comb begin
    total_n = '0;
    for (int i = 0; i < els_p; i++)
      total_n = total_n + total_width_lp'(cnt_n[i]);
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      total_r <= '0;
      empty_r <= 1'b1;
    end else begin
      total_r <= total_n;
      empty_r <= (total_n == '0);
    end

  assign total_pending_o = total_r;
  assign empty_o         = empty_r;

endmodule

// File: tb/tb_vanilla_remote_load_scoreboard.sv
module tb_vanilla_remote_load_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        score_v;
  logic [4:0]  score_id;
  logic        score_ready;
  logic [1:0]  clear_v;
  logic [9:0]  clear_id;
  logic [2:0]  src_v;
  logic [14:0] src_id;
  logic        dst_v;
  logic [4:0]  dst_id;
  logic        dep;
  logic [31:0] pending;
  logic [6:0]  total;
  logic        empty;

  always #5 clk = ~clk;

  vanilla_remote_load_scoreboard dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .score_v_i       (score_v),
    .score_id_i      (score_id),
    .score_ready_o   (score_ready),
    .clear_v_i       (clear_v),
    .clear_id_i      (clear_id),
    .src_v_i         (src_v),
    .src_id_i        (src_id),
    .dst_v_i         (dst_v),
    .dst_id_i        (dst_id),
    .dep_o           (dep),
    .pending_o       (pending),
    .total_pending_o (total),
    .empty_o         (empty)
  );

  typedef struct {
    logic [31:0] pend;
    logic [31:0] tot;
    logic        emp;
  } exp_t;

  exp_t exp_q[$];
  int   mcnt[32];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    score_v = 0; score_id = 0; clear_v = 0; clear_id = 0;
    src_v = 0; src_id = 0; dst_v = 0; dst_id = 0;
  endtask

  // Drive one cycle (entered just after a posedge). Combinational outputs are
  // checked against the model mid-cycle; registered outputs are queued and
  // checked after the next edge.
  task automatic cyc(input logic sv, input logic [4:0] sid,
                     input logic [1:0] cv, input logic [4:0] c0, input logic [4:0] c1,
                     input logic [2:0] srv, input logic [4:0] s0, input logic [4:0] s1,
                     input logic [4:0] s2, input logic dv, input logic [4:0] did);
    int   d[32];
    int   eff;
    int   n;
    logic e_dep, e_rdy;
    logic [4:0] ss[3];
    exp_t e, g;
    score_v = sv; score_id = sid; clear_v = cv; clear_id = {c1, c0};
    src_v = srv; src_id = {s2, s1, s0}; dst_v = dv; dst_id = did;
    ss[0] = s0; ss[1] = s1; ss[2] = s2;
    for (int i = 0; i < 32; i++) d[i] = 0;
    if (cv[0]) d[c0]++;
    if (cv[1]) d[c1]++;
    e_rdy = (sid == 0) || (mcnt[sid] != 3);
    e_dep = 0;
    for (int s = 0; s < 3; s++) begin
      eff = (ss[s] == 0) ? 0 : mcnt[ss[s]] - d[ss[s]];
      if (srv[s] && eff > 0) e_dep = 1;
    end
    eff = (did == 0) ? 0 : mcnt[did] - d[did];
    if (dv && eff > 0) e_dep = 1;
    #1;
    chk("score_ready", {31'b0, score_ready}, {31'b0, e_rdy});
    chk("dep", {31'b0, dep}, {31'b0, e_dep});
    e.pend = 0; e.tot = 0;
    for (int i = 1; i < 32; i++) begin
      n = mcnt[i] + ((sv && sid == i && mcnt[i] != 3) ? 1 : 0) - d[i];
      mcnt[i] = (n < 0) ? 0 : n;
      e.pend[i] = (mcnt[i] != 0);
      e.tot += mcnt[i];
    end
    e.emp = (e.tot == 0);
    exp_q.push_back(e);
    @(posedge clk); #1;
    idle_inputs();
    if (exp_q.size() == 0) chk("queue_underrun", 0, 1);
    else begin
      g = exp_q.pop_front();
      chk("pending", pending, g.pend);
      chk("total", {25'b0, total}, g.tot);
      chk("empty", {31'b0, empty}, {31'b0, g.emp});
    end
  endtask

  task automatic score(input logic [4:0] id);
    cyc(1, id, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_total"}, {25'b0, total}, 0);
    chk({tag, "_empty"}, {31'b0, empty}, 1);
  endtask

  initial begin
    logic       sv;
    logic [4:0] sid, c0, c1, s0, s1, s2, did;
    logic [1:0] cv;
    int         dd[32];
    int         avail;

    idle_inputs();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 0;
    @(posedge clk); #1;

    // Fill id 5 to saturation; the idle cycle after checks ready=0 for id 5.
    score(5); score(5); score(5);
    cyc(0, 5, 0, 0, 0, 1, 5, 0, 0, 0, 0);

    // Clear bypass: clear 7 while src0 reads 7 -> no dependency.
    score(7);
    cyc(0, 0, 2'b01, 7, 0, 3'b001, 7, 0, 0, 0, 0);

    // Two clears to id 9 in one cycle.
    score(9); score(9);
    cyc(0, 0, 2'b11, 9, 9, 3'b000, 0, 0, 0, 1, 9);

    // Score and clear id 3 together: count stays at 1, dep still seen.
    score(3);
    cyc(1, 3, 2'b01, 3, 0, 3'b010, 0, 3, 0, 0, 0);
    cyc(0, 3, 0, 0, 0, 3'b000, 0, 0, 0, 1, 3);

    // Register 0 is never scored.
    cyc(1, 0, 0, 0, 0, 3'b111, 0, 0, 0, 1, 0);

    // Drain everything to reach empty.
    cyc(0, 0, 2'b11, 5, 5, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 2'b11, 5, 3, 0, 0, 0, 0, 0, 0);

    // Random legal traffic on a narrow id range so collisions are common.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 32; i++) dd[i] = 0;
      sv  = 1'($urandom_range(0, 1));
      sid = 5'($urandom_range(0, 7));
      if (sid != 0 && mcnt[sid] == 3) sv = 0;
      c0 = 5'($urandom_range(0, 7));
      c1 = 5'($urandom_range(0, 7));
      cv = 2'($urandom_range(0, 3));
      avail = mcnt[c0] + ((sv && sid == c0) ? 1 : 0);
      if (cv[0] && c0 != 0) begin
        if (avail > 0) dd[c0]++;
        else cv[0] = 0;
      end
      avail = mcnt[c1] + ((sv && sid == c1) ? 1 : 0) - dd[c1];
      if (cv[1] && c1 != 0 && avail <= 0) cv[1] = 0;
      s0  = 5'($urandom_range(0, 7));
      s1  = 5'($urandom_range(0, 7));
      s2  = 5'($urandom_range(0, 7));
      did = 5'($urandom_range(0, 7));
      cyc(sv, sid, cv, c0, c1, 3'($urandom_range(0, 7)), s0, s1, s2,
          1'($urandom_range(0, 1)), did);
    end

    // Drain, then build cnt[4]=2, cnt[6]=1 and reset mid-cycle.
    for (int i = 1; i < 32; i++)
      while (mcnt[i] > 0) cyc(0, 0, 2'b01, 5'(i), 0, 0, 0, 0, 0, 0, 0);
    score(4); score(4); score(6);
    #3;
    rst = 1;
    #1;
    chk_reset_state("async_reset");
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk_reset_state("post_reset");
    cyc(0, 4, 0, 0, 0, 3'b001, 4, 0, 0, 1, 6);

    if (exp_q.size() != 0) chk("queue_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
